// File: rtl/alpha_col_packer.sv
// alpha_col_packer: packs a scalar stream of doubles into J-element columns, with tlast on column I-1 of each frame.
// Optional feature macro ZERO_PAD_EN: an early s_tlast zero-fills and emits the partial column instead of dropping it.
module alpha_col_packer #(
   parameter int J   = 14,
   parameter int I   = 7,
   parameter int GAP = 0
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [63:0]          s_tdata,
   input  logic                 s_tvalid,
   output logic                 s_tready,
   input  logic                 s_tlast,
   output logic [J*64-1:0]      alpha_u_col,
   output logic                 alpha_u_col_tvalid,
   output logic                 alpha_u_col_tlast,
   output logic                 frame_err,
   output logic [$clog2(I)-1:0] col_cnt
);

   localparam int EW = (J > 1) ? $clog2(J) : 1;
   localparam int CW = $clog2(I);
   localparam logic [EW-1:0] E_LAST   = EW'(J - 1);
   localparam logic [CW-1:0] C_LAST   = CW'(I - 1);
   localparam logic [3:0]    GAP_LOAD = 4'((GAP > 0) ? GAP - 1 : 0);
   localparam bit            GAP_EN   = (GAP > 0);

   typedef enum logic [0:0] {ST_FILL = 1'b0, ST_GAP = 1'b1} state_t;

   state_t          state_r, state_nx_s;
   logic [3:0]      gap_cnt_r;
   logic            ready_r, ready_nx_s;
   logic [EW-1:0]   e_r;
   logic [CW-1:0]   col_r;
   logic [J*64-1:0] buf_r, buf_nx_s, col_out_r;
   logic            tvalid_r, tlast_r, ferr_r;
   logic            accept_s, last_e_s, last_c_s, frame_end_s, early_s, emit_s, ferr_nx_s;

   // Beat classification: completed column, early tlast, or frame end without tlast
   always_comb begin
      accept_s    = s_tvalid & ready_r;
      last_e_s    = (e_r == E_LAST);
      last_c_s    = (col_r == C_LAST);
      frame_end_s = last_e_s & last_c_s;
      early_s     = accept_s & s_tlast & ~frame_end_s;
`ifdef ZERO_PAD_EN
      emit_s      = accept_s & (last_e_s | s_tlast);
`else
      emit_s      = accept_s & last_e_s & ~early_s;
`endif
      ferr_nx_s   = (accept_s & frame_end_s & ~s_tlast) | early_s;
   end

   // Shift buffer next value: write slot e, optionally zero the slots above it on early tlast
   always_comb begin
      buf_nx_s = buf_r;
      for (int k = 0; k < J; k++) begin
         if (accept_s && (EW'(k) == e_r)) begin
            buf_nx_s[(J-k)*64-1 -: 64] = s_tdata;
`ifdef ZERO_PAD_EN
         end else if (accept_s && s_tlast && (EW'(k) > e_r)) begin
            buf_nx_s[(J-k)*64-1 -: 64] = 64'd0;
`endif
         end else begin
            buf_nx_s[(J-k)*64-1 -: 64] = buf_r[(J-k)*64-1 -: 64];
         end
      end
   end

   // State register and gap countdown
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= ST_FILL;
         gap_cnt_r <= 4'd0;
         ready_r   <= 1'b0;
      end else begin
         state_r <= state_nx_s;
         ready_r <= ready_nx_s;
         if (state_r == ST_FILL) begin
            gap_cnt_r <= GAP_LOAD;
         end else if (gap_cnt_r != 4'd0) begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
         end else begin
            gap_cnt_r <= gap_cnt_r;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_FILL: begin
            if (emit_s && GAP_EN) state_nx_s = ST_GAP;
            else                  state_nx_s = ST_FILL;
         end
         ST_GAP: begin
            if (gap_cnt_r == 4'd0) state_nx_s = ST_FILL;
            else                   state_nx_s = ST_GAP;
         end
         default: state_nx_s = ST_FILL;
      endcase
   end

   // Output decode: ready is registered from the next state
   always_comb begin
      ready_nx_s = 1'b0;
      case (state_nx_s)
         ST_FILL: ready_nx_s = 1'b1;
         ST_GAP:  ready_nx_s = 1'b0;
         default: ready_nx_s = 1'b0;
      endcase
   end

   // Datapath: counters, shift buffer and the column output register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         e_r       <= '0;
         col_r     <= '0;
         buf_r     <= '0;
         col_out_r <= '0;
         tvalid_r  <= 1'b0;
         tlast_r   <= 1'b0;
         ferr_r    <= 1'b0;
      end else begin
         tvalid_r <= emit_s;
         tlast_r  <= emit_s & (last_c_s | early_s);
         ferr_r   <= ferr_nx_s;
         if (emit_s) col_out_r <= buf_nx_s;
         if (emit_s || early_s)  buf_r <= '0;
         else if (accept_s)      buf_r <= buf_nx_s;
         if (early_s) begin
            e_r   <= '0;
            col_r <= '0;
         end else if (accept_s) begin
            if (last_e_s) begin
               e_r   <= '0;
               col_r <= last_c_s ? '0 : col_r + CW'(1);
            end else begin
               e_r <= e_r + EW'(1);
            end
         end
      end
   end

   assign s_tready           = ready_r;
   assign alpha_u_col        = col_out_r;
   assign alpha_u_col_tvalid = tvalid_r;
   assign alpha_u_col_tlast  = tlast_r;
   assign frame_err          = ferr_r;
   assign col_cnt            = col_r;

endmodule

// File: tb/tb_alpha_col_packer.sv
// tb_alpha_col_packer: directed bench for alpha_col_packer; u_dut0 runs with GAP=0, u_dut1 with GAP=2.
// Beats carry the doubles 1.0, 2.0, ... so each expected column is rebuilt from its first element number.
module tb_alpha_col_packer;
   localparam int J = 14;
   localparam int I = 7;
   localparam int CWID = J * 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [63:0]     s_tdata;
   logic            s_tvalid, s_tlast;
   logic            rdy0, rdy1, tv0, tv1, tl0, tl1, fe0, fe1;
   logic [CWID-1:0] col0, col1;
   logic [2:0]      cc0, cc1;

   alpha_col_packer #(.J(J), .I(I), .GAP(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy0),
      .s_tlast(s_tlast), .alpha_u_col(col0), .alpha_u_col_tvalid(tv0), .alpha_u_col_tlast(tl0),
      .frame_err(fe0), .col_cnt(cc0));

   alpha_col_packer #(.J(J), .I(I), .GAP(2)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(rdy1),
      .s_tlast(s_tlast), .alpha_u_col(col1), .alpha_u_col_tvalid(tv1), .alpha_u_col_tlast(tl1),
      .frame_err(fe1), .col_cnt(cc1));

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_eq(input string tag, input logic [CWID-1:0] obs, input logic [CWID-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Column monitor, sampled on the falling edge
   logic [CWID-1:0] cq0[$], cq1[$];
   bit              tq0[$], fq0[$], tq1[$];
   int              tvc0[$];
   int              ferr0 = 0;
   int              cyc = 0;
   always @(negedge clk) begin
      cyc++;
      if (tv0) begin
         cq0.push_back(col0); tq0.push_back(tl0); fq0.push_back(fe0); tvc0.push_back(cyc);
      end
      if (tv1) begin
         cq1.push_back(col1); tq1.push_back(tl1);
      end
      if (fe0) ferr0++;
   end

   function automatic logic [CWID-1:0] exp_col(input int first, input int nvalid);
      logic [CWID-1:0] c;
      c = '0;
      for (int s = 0; s < nvalid; s++) c[(J-s)*64-1 -: 64] = $realtobits(real'(first + s));
      return c;
   endfunction

   task automatic clear_mon();
      cq0.delete(); tq0.delete(); fq0.delete(); tvc0.delete();
      cq1.delete(); tq1.delete();
      ferr0 = 0;
   endtask

   task automatic do_reset();
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 64'd0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
   endtask

   // Present one beat after 'idle' empty cycles and hold it until u_dut0 accepts it
   task automatic send(input int v, input bit last, input int idle);
      int t;
      t = 0;
      repeat (idle) begin @(posedge clk); #1; end
      s_tdata = $realtobits(real'(v)); s_tlast = last; s_tvalid = 1'b1;
      while (!rdy0 && t < 50) begin @(posedge clk); #1; t++; end
      if (t >= 50) begin
         n_checks++; n_errors++;
         $display("FAIL send_timeout: got ready=0 after %0d cycles, required ready=1", t);
      end
      @(posedge clk); #1;
      s_tvalid = 1'b0; s_tlast = 1'b0;
   endtask

   task automatic send_frame(input int first, input int n, input bit last_on_end, input int idle_max);
      for (int k = 0; k < n; k++) send(first + k, last_on_end && (k == n - 1), $urandom_range(0, idle_max));
   endtask

   task automatic check_full_frame(input string tag);
      check_eq({tag, "_ncol"}, CWID'(cq0.size()), CWID'(7));
      for (int k = 0; k < 7 && k < cq0.size(); k++) begin
         check_eq({tag, "_col"}, cq0[k], exp_col(k * 14 + 1, 14));
         check_eq({tag, "_tlast"}, CWID'(tq0[k]), CWID'(k == 6));
      end
   endtask

   initial begin : main
      int n, t, exp_low;
      bit r;

      // Reset state
      s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 64'd0;
      repeat (2) @(posedge clk); #1;
      check_eq("rst_ready", CWID'(rdy0), CWID'(0));
      check_eq("rst_tvalid", CWID'(tv0), CWID'(0));
      check_eq("rst_tlast", CWID'(tl0), CWID'(0));
      check_eq("rst_ferr", CWID'(fe0), CWID'(0));
      check_eq("rst_colcnt", CWID'(cc0), CWID'(0));
      check_eq("rst_col", col0, '0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_eq("rst_ready_after", CWID'(rdy0), CWID'(1));
      clear_mon();

      // T1: clean frame, back-to-back beats
      send_frame(1, 98, 1'b1, 0);
      repeat (3) @(posedge clk); #1;
      check_full_frame("t1");
      check_eq("t1_ferr", CWID'(ferr0), CWID'(0));
      if (tvc0.size() == 7) check_eq("t1_spacing", CWID'(tvc0[6] - tvc0[0]), CWID'(84));

      // T2: GAP=2 with s_tvalid held high; ready is checked every cycle
      do_reset();
      n = 1; t = 0; exp_low = 0;
      s_tvalid = 1'b1; s_tdata = $realtobits(1.0); s_tlast = 1'b0;
      while (n <= 98 && t < 400) begin
         r = rdy1;
         check_eq("t2_ready", CWID'(r), CWID'(exp_low == 0));
         if (exp_low > 0) exp_low--;
         @(posedge clk); #1; t++;
         if (r) begin
            if (n % 14 == 0) exp_low = 2;
            n++;
            s_tdata = $realtobits(real'(n));
            s_tlast = (n == 98);
         end
      end
      s_tvalid = 1'b0; s_tlast = 1'b0;
      check_eq("t2_all_beats", CWID'(n), CWID'(99));
      repeat (4) @(posedge clk); #1;
      check_eq("t2_ncol", CWID'(cq1.size()), CWID'(7));
      for (int k = 0; k < 7 && k < cq1.size(); k++) begin
         check_eq("t2_col", cq1[k], exp_col(k * 14 + 1, 14));
         check_eq("t2_tlast", CWID'(tq1[k]), CWID'(k == 6));
      end

      // T3: early s_tlast on beat 20 (col1, e=5), then one more full column
      do_reset();
      send_frame(1, 20, 1'b1, 0);
      check_eq("t3_colcnt", CWID'(cc0), CWID'(0));
      send_frame(21, 14, 1'b0, 0);
      repeat (3) @(posedge clk); #1;
      check_eq("t3_ferr", CWID'(ferr0), CWID'(1));
`ifdef ZERO_PAD_EN
      check_eq("t3_ncol", CWID'(cq0.size()), CWID'(3));
      if (cq0.size() == 3) begin
         check_eq("t3_col0", cq0[0], exp_col(1, 14));
         check_eq("t3_tlast0", CWID'(tq0[0]), CWID'(0));
         check_eq("t3_padcol", cq0[1], exp_col(15, 6));
         check_eq("t3_padtlast", CWID'(tq0[1]), CWID'(1));
         check_eq("t3_next", cq0[2], exp_col(21, 14));
         check_eq("t3_nexttlast", CWID'(tq0[2]), CWID'(0));
      end
`else
      check_eq("t3_ncol", CWID'(cq0.size()), CWID'(2));
      if (cq0.size() == 2) begin
         check_eq("t3_col0", cq0[0], exp_col(1, 14));
         check_eq("t3_tlast0", CWID'(tq0[0]), CWID'(0));
         check_eq("t3_next", cq0[1], exp_col(21, 14));
         check_eq("t3_nexttlast", CWID'(tq0[1]), CWID'(0));
      end
`endif

      // T4: frame without s_tlast, then beats 99..112 start a new frame
      do_reset();
      send_frame(1, 98, 1'b0, 0);
      send_frame(99, 14, 1'b0, 0);
      repeat (3) @(posedge clk); #1;
      check_eq("t4_ncol", CWID'(cq0.size()), CWID'(8));
      if (cq0.size() == 8) begin
         check_eq("t4_col6", cq0[6], exp_col(85, 14));
         check_eq("t4_tlast6", CWID'(tq0[6]), CWID'(1));
         check_eq("t4_ferr_with_col6", CWID'(fq0[6]), CWID'(1));
         check_eq("t4_ferr_col5", CWID'(fq0[5]), CWID'(0));
         check_eq("t4_col7", cq0[7], exp_col(99, 14));
         check_eq("t4_tlast7", CWID'(tq0[7]), CWID'(0));
      end
      check_eq("t4_ferr_cnt", CWID'(ferr0), CWID'(1));

      // T5: reset in the middle of column 1
      do_reset();
      send_frame(1, 23, 1'b0, 0);
      check_eq("t5_colcnt_pre", CWID'(cc0), CWID'(1));
      #2 rst_n = 1'b0;
      #1;
      check_eq("t5_tvalid", CWID'(tv0), CWID'(0));
      check_eq("t5_tlast", CWID'(tl0), CWID'(0));
      check_eq("t5_ferr", CWID'(fe0), CWID'(0));
      check_eq("t5_colcnt", CWID'(cc0), CWID'(0));
      check_eq("t5_ready", CWID'(rdy0), CWID'(0));
      check_eq("t5_col", col0, '0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      clear_mon();
      send_frame(201, 14, 1'b0, 0);
      repeat (3) @(posedge clk); #1;
      check_eq("t5_ncol", CWID'(cq0.size()), CWID'(1));
      if (cq0.size() == 1) begin
         check_eq("t5_col0", cq0[0], exp_col(201, 14));
         check_eq("t5_tlast0", CWID'(tq0[0]), CWID'(0));
      end

      // T6: T1 data with random idle cycles between beats
      do_reset();
      send_frame(1, 98, 1'b1, 3);
      repeat (3) @(posedge clk); #1;
      check_full_frame("t6");
      check_eq("t6_ferr", CWID'(ferr0), CWID'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
